// File: rtl/stream_arbiter_qos_pkt_pkg.sv
// Shared types and helpers for the packet-locked QoS stream arbiter.
package stream_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Effective priority is {urgent, qos}: one bit wider than the QoS field.
  function automatic int eff_prio_width(input int qos_width);
    return qos_width + 1;
  endfunction

endpackage

// File: rtl/stream_arbiter_qos_pkt_if.sv
// N input streams plus one merged output stream of the QoS packet arbiter.
interface stream_arbiter_qos_pkt_if #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 4
);
  localparam int T_ID___WIDTH = (STREAM_COUNT > 1) ? $clog2(STREAM_COUNT) : 1;

  // A beat moves on a rising edge exactly when valid && ready are both high;
  // valid never waits on ready, while ready may depend combinationally on valid.
  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i;
  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] s_qos_i;
  logic [STREAM_COUNT-1:0]                   s_last_i;
  logic [STREAM_COUNT-1:0]                   s_valid_i;
  logic [STREAM_COUNT-1:0]                   s_ready_o;
  logic [T_DATA_WIDTH-1:0]                   m_data_o;
  logic [T_QOS__WIDTH-1:0]                   m_qos_o;
  logic [T_ID___WIDTH-1:0]                   m_id_o;
  logic                                      m_last_o;
  logic                                      m_valid_o;
  logic                                      m_ready_i;

  modport slave (
    input  s_data_i, s_qos_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_qos_o, m_id_o, m_last_o, m_valid_o
  );

  modport master (
    output s_data_i, s_qos_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_qos_o, m_id_o, m_last_o, m_valid_o
  );

endinterface

// File: rtl/stream_arbiter_qos_pkt_qos_rr_select.sv
// Combinational pick: highest effective priority wins, ties resolved round-robin after rr_ptr.
module qos_rr_select #(
  parameter int N   = 4,
  parameter int PW  = 5,
  parameter int IDW = 2
) (
  input  logic [N-1:0]         req,
  input  logic [N-1:0][PW-1:0] prio,
  input  logic [IDW-1:0]       rr_ptr,
  output logic [N-1:0]         grant,
  output logic [IDW-1:0]       id
);

  logic [PW-1:0] best;
  logic [N-1:0]  cand;
  logic          found;
  int            idx;

  always_comb begin
    best  = '0;
    cand  = '0;
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (prio[i] > best)) best = prio[i];
    end
    for (int i = 0; i < N; i++) begin
      cand[i] = req[i] && (prio[i] == best);
    end
    // Walk rr_ptr+1 .. rr_ptr+N with wrap; the first tied candidate wins.
    for (int k = 1; k <= N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && cand[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_arbiter_qos_pkt.sv
// Packet-locked N:1 stream arbiter with QoS, round-robin ties, starvation aging and a registered output slot.
module stream_arbiter_qos_pkt
  import stream_arbiter_pkg::*;
#(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 4,
  parameter int AGE_WIDTH    = 4,
  parameter int AGE_LIMIT    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  stream_arbiter_qos_pkt_if.slave bus,
  output arb_state_e              dbg_state
);

  localparam int T_ID___WIDTH = (STREAM_COUNT > 1) ? $clog2(STREAM_COUNT) : 1;
  localparam int PW           = eff_prio_width(T_QOS__WIDTH);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = AGE_WIDTH'(AGE_LIMIT);

  arb_state_e                                state, state_nxt;
  logic [T_ID___WIDTH-1:0]                   rr_ptr;
  logic [STREAM_COUNT-1:0][AGE_WIDTH-1:0]    age;
  logic [T_ID___WIDTH-1:0]                   lock_id;
  logic [T_QOS__WIDTH-1:0]                   lock_qos;
  logic [STREAM_COUNT-1:0][PW-1:0]           eff_prio;
  logic [STREAM_COUNT-1:0]                   sel_grant;
  logic [T_ID___WIDTH-1:0]                   sel_id;
  logic [STREAM_COUNT-1:0]                   grant;
  logic [STREAM_COUNT-1:0]                   s_ready;
  logic [T_ID___WIDTH-1:0]                   acc_id;
  logic                                      slot_free, accept, start;

  logic [T_DATA_WIDTH-1:0] m_data_q;
  logic [T_QOS__WIDTH-1:0] m_qos_q;
  logic [T_ID___WIDTH-1:0] m_id_q;
  logic                    m_last_q;
  logic                    m_valid_q;

  always_comb begin
    eff_prio = '0;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      eff_prio[i] = {(age[i] == AGE_MAX), bus.s_qos_i[i]};
    end
  end

  qos_rr_select #(
    .N   (STREAM_COUNT),
    .PW  (PW),
    .IDW (T_ID___WIDTH)
  ) u_select (
    .req    (bus.s_valid_i),
    .prio   (eff_prio),
    .rr_ptr (rr_ptr),
    .grant  (sel_grant),
    .id     (sel_id)
  );

  assign slot_free = !m_valid_q || bus.m_ready_i;

  always_comb begin
    grant = '0;
    if (state == ARB_LOCKED) grant[lock_id] = 1'b1;
    else                     grant = sel_grant;
    // Ready is gated by valid so an idle or waiting stream never sees speculative ready.
    s_ready   = (rst || !slot_free) ? '0 : (grant & bus.s_valid_i);
    accept    = |s_ready;
    acc_id    = (state == ARB_LOCKED) ? lock_id : sel_id;
    start     = accept && (state == ARB_IDLE);
    state_nxt = state;
    case (state)
      ARB_IDLE:   if (accept && !bus.s_last_i[acc_id]) state_nxt = ARB_LOCKED;
      ARB_LOCKED: if (accept &&  bus.s_last_i[acc_id]) state_nxt = ARB_IDLE;
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      rr_ptr    <= T_ID___WIDTH'(STREAM_COUNT - 1);
      age       <= '0;
      lock_id   <= '0;
      lock_qos  <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_qos_q   <= '0;
      m_id_q    <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        rr_ptr   <= sel_id;
        lock_id  <= sel_id;
        lock_qos <= bus.s_qos_i[sel_id];
        // Losers still waiting age by one per packet start; the winner starts over.
        for (int i = 0; i < STREAM_COUNT; i++) begin
          if (i == int'(sel_id))
            age[i] <= '0;
          else if (bus.s_valid_i[i] && (age[i] != AGE_MAX))
            age[i] <= age[i] + AGE_WIDTH'(1);
        end
      end
      if (accept) begin
        m_valid_q <= 1'b1;
        m_data_q  <= bus.s_data_i[acc_id];
        m_qos_q   <= start ? bus.s_qos_i[sel_id] : lock_qos;
        m_id_q    <= acc_id;
        m_last_q  <= bus.s_last_i[acc_id];
      end else if (bus.m_ready_i) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign bus.s_ready_o = s_ready;
  assign bus.m_valid_o = m_valid_q;
  assign bus.m_data_o  = m_data_q;
  assign bus.m_qos_o   = m_qos_q;
  assign bus.m_id_o    = m_id_q;
  assign bus.m_last_o  = m_last_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_stream_arbiter_qos_pkt.sv
// Bench for stream_arbiter_qos_pkt: vector table, directed corner sequences and a random run against a reference model.
module tb_stream_arbiter_qos_pkt;
  import stream_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int QW = 4;
  localparam int AW = 4;
  localparam int AL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  arb_state_e dbg_state;

  stream_arbiter_qos_pkt_if #(.T_DATA_WIDTH(DW), .T_QOS__WIDTH(QW), .STREAM_COUNT(N)) ifc ();

  stream_arbiter_qos_pkt #(
    .T_DATA_WIDTH (DW),
    .T_QOS__WIDTH (QW),
    .STREAM_COUNT (N),
    .AGE_WIDTH    (AW),
    .AGE_LIMIT    (AL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  int           age_m [N];
  int           rr_m;
  bit           locked_m;
  int           lock_id_m;
  logic [3:0]   lock_qos_m;
  logic [5:0]   seq_m [N];
  logic [14:0]  exp_q [$];      // {data, qos, id, last} of beats owed on the output
  logic [N-1:0] exp_ready;
  bit           prev_last;
  int           prev_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      age_m[i] = 0;
      seq_m[i] = '0;
    end
    rr_m       = N - 1;
    locked_m   = 1'b0;
    lock_id_m  = 0;
    lock_qos_m = '0;
    exp_q.delete();
    prev_last  = 1'b1;
    prev_id    = 0;
  endfunction

  // Winner = largest (urgent*16 + qos); ties go to the smallest distance past rr_m.
  function automatic int pick(input logic [N-1:0] v, input logic [4*N-1:0] q);
    int best = -1;
    int bk   = -1;
    int bd   = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        int key = ((age_m[i] >= AL) ? 16 : 0) + int'(q[4*i +: 4]);
        int d   = (i - rr_m - 1 + 2 * N) % N;
        if (key > bk || (key == bk && d < bd)) begin
          best = i;
          bk   = key;
          bd   = d;
        end
      end
    end
    return best;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic run_cycle(input logic [N-1:0] v, input logic [N-1:0] l,
                           input logic [4*N-1:0] q, input logic mr, input logic r);
    int g;
    logic [3:0] qb;
    @(negedge clk);
    rst           = r;
    ifc.s_valid_i = v;
    ifc.s_last_i  = l;
    ifc.m_ready_i = mr;
    for (int i = 0; i < N; i++) begin
      ifc.s_qos_i[i]  = q[4*i +: 4];
      ifc.s_data_i[i] = {2'(i), seq_m[i]};
    end
    #1;
    chk("m_valid", 32'(ifc.m_valid_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      chk("m_beat", {ifc.m_data_o, ifc.m_qos_o, ifc.m_id_o, ifc.m_last_o}, exp_q[0]);
    chk("fsm_state", 32'(dbg_state), 32'(locked_m ? ARB_LOCKED : ARB_IDLE));

    exp_ready = '0;
    if (!r && (exp_q.size() == 0 || mr)) begin
      if (locked_m) begin
        if (v[lock_id_m]) exp_ready[lock_id_m] = 1'b1;
      end else begin
        g = pick(v, q);
        if (g >= 0) exp_ready[g] = 1'b1;
      end
    end
    chk("s_ready", 32'(ifc.s_ready_o), 32'(exp_ready));
    chk("ready_onehot", 32'($countones(ifc.s_ready_o) <= 1), 32'd1);

    if (exp_q.size() != 0 && mr) begin
      if (!prev_last) chk("no_interleave", 32'(ifc.m_id_o), 32'(prev_id));
      prev_id   = int'(ifc.m_id_o);
      prev_last = ifc.m_last_o;
      void'(exp_q.pop_front());
    end

    if (r) begin
      model_reset();
    end else if (exp_ready != '0) begin
      g = 0;
      for (int i = 0; i < N; i++) if (exp_ready[i]) g = i;
      qb = locked_m ? lock_qos_m : q[4*g +: 4];
      exp_q.push_back({2'(g), seq_m[g], qb, 2'(g), l[g]});
      if (!locked_m) begin
        for (int j = 0; j < N; j++)
          if (j != g && v[j] && age_m[j] < AL) age_m[j]++;
        age_m[g]   = 0;
        rr_m       = g;
        lock_id_m  = g;
        lock_qos_m = q[4*g +: 4];
        locked_m   = !l[g];
      end else if (l[g]) begin
        locked_m = 1'b0;
      end
      seq_m[g] = seq_m[g] + 6'd1;
    end
  endtask

  task automatic do_reset();
    run_cycle('0, '0, '0, 1'b1, 1'b1);
    run_cycle('0, '0, '0, 1'b1, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         rf;       // reset before this row
    logic [N-1:0] v;
    logic [N-1:0] l;
    logic [15:0]  q;
    logic [N-1:0] exp_rdy;
    logic         exp_mv;
    logic [1:0]   exp_id;
    logic [3:0]   exp_qos;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int n, first3, second3;
    model_reset();
    ifc.s_valid_i = '0;
    ifc.s_last_i  = '0;
    ifc.s_qos_i   = '0;
    ifc.s_data_i  = '0;
    ifc.m_ready_i = 1'b1;

    // Round-robin among equal QoS single-beat packets: ids 0,1,2,3,0.
    tbl[0]  = '{1'b1, 4'hF, 4'hF, 16'h2222, 4'b0001, 1'b0, 2'd0, 4'd0};
    tbl[1]  = '{1'b0, 4'hF, 4'hF, 16'h2222, 4'b0010, 1'b1, 2'd0, 4'd2};
    tbl[2]  = '{1'b0, 4'hF, 4'hF, 16'h2222, 4'b0100, 1'b1, 2'd1, 4'd2};
    tbl[3]  = '{1'b0, 4'hF, 4'hF, 16'h2222, 4'b1000, 1'b1, 2'd2, 4'd2};
    tbl[4]  = '{1'b0, 4'hF, 4'hF, 16'h2222, 4'b0001, 1'b1, 2'd3, 4'd2};
    tbl[5]  = '{1'b0, 4'h0, 4'h0, 16'h2222, 4'b0000, 1'b1, 2'd0, 4'd2};
    tbl[6]  = '{1'b0, 4'h0, 4'h0, 16'h2222, 4'b0000, 1'b0, 2'd0, 4'd0};
    // Stream 1 locks a 3-beat packet (qos 1) while stream 2 asks with qos 15;
    // stream 1's qos changes mid-packet and its valid drops for one cycle.
    tbl[7]  = '{1'b1, 4'b0010, 4'b0000, 16'h0010, 4'b0010, 1'b0, 2'd0, 4'd0};
    tbl[8]  = '{1'b0, 4'b0110, 4'b0000, 16'h0F90, 4'b0010, 1'b1, 2'd1, 4'd1};
    tbl[9]  = '{1'b0, 4'b0100, 4'b0100, 16'h0F90, 4'b0000, 1'b1, 2'd1, 4'd1};
    tbl[10] = '{1'b0, 4'b0110, 4'b0010, 16'h0F90, 4'b0010, 1'b0, 2'd0, 4'd0};
    tbl[11] = '{1'b0, 4'b0100, 4'b0100, 16'h0F90, 4'b0100, 1'b1, 2'd1, 4'd1};
    tbl[12] = '{1'b0, 4'b0000, 4'b0000, 16'h0F90, 4'b0000, 1'b1, 2'd2, 4'd15};
    tbl[13] = '{1'b0, 4'b0000, 4'b0000, 16'h0F90, 4'b0000, 1'b0, 2'd0, 4'd0};

    for (int k = 0; k < 14; k++) begin
      if (tbl[k].rf) do_reset();
      run_cycle(tbl[k].v, tbl[k].l, tbl[k].q, 1'b1, 1'b0);
      chk($sformatf("tbl%0d_ready", k), 32'(ifc.s_ready_o), 32'(tbl[k].exp_rdy));
      chk($sformatf("tbl%0d_mvalid", k), 32'(ifc.m_valid_o), 32'(tbl[k].exp_mv));
      if (tbl[k].exp_mv) begin
        chk($sformatf("tbl%0d_mid", k), 32'(ifc.m_id_o), 32'(tbl[k].exp_id));
        chk($sformatf("tbl%0d_mqos", k), 32'(ifc.m_qos_o), 32'(tbl[k].exp_qos));
      end
    end

    // Aging: stream 3 (qos 0) against two qos-7 streams wins on the 9th start,
    // then needs another 9 starts because its age restarted from zero.
    do_reset();
    n = 0;
    first3 = 0;
    second3 = 0;
    for (int c = 0; c < 40 && second3 == 0; c++) begin
      run_cycle(4'b1011, 4'hF, 16'h0077, 1'b1, 1'b0);
      if (ifc.s_ready_o != '0) n++;
      if (ifc.s_ready_o[3]) begin
        if (first3 == 0) first3 = n;
        else             second3 = n;
      end
    end
    chk("age_first_urgent", 32'(first3), 32'd9);
    chk("age_cleared", 32'(second3 - first3), 32'd9);

    // Output stall for 5 cycles holds beat seq=1 of stream 0.
    do_reset();
    run_cycle(4'b0001, 4'b0001, '0, 1'b1, 1'b0);
    run_cycle(4'b0001, 4'b0001, '0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      run_cycle(4'b0001, 4'b0001, '0, 1'b0, 1'b0);
      chk("stall_ready", 32'(ifc.s_ready_o), 32'd0);
      chk("stall_valid", 32'(ifc.m_valid_o), 32'd1);
      chk("stall_data", 32'(ifc.m_data_o), 32'h01);
    end
    for (int k = 0; k < 3; k++) run_cycle(4'b0001, 4'b0001, '0, 1'b1, 1'b0);
    run_cycle('0, '0, '0, 1'b1, 1'b0);
    run_cycle('0, '0, '0, 1'b1, 1'b0);

    // Reset in the middle of a 4-beat packet from stream 2.
    do_reset();
    run_cycle(4'b0100, 4'b0000, '0, 1'b1, 1'b0);
    chk("rst_pre_accept", 32'(ifc.s_ready_o), 32'b0100);
    run_cycle(4'b0100, 4'b0000, '0, 1'b1, 1'b1);
    chk("rst_cycle_ready", 32'(ifc.s_ready_o), 32'd0);
    run_cycle(4'hF, 4'hF, 16'h3333, 1'b1, 1'b0);
    chk("rst_mvalid", 32'(ifc.m_valid_o), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
    chk("rst_first_grant", 32'(ifc.s_ready_o), 32'b0001);
    run_cycle('0, '0, '0, 1'b1, 1'b0);
    run_cycle('0, '0, '0, 1'b1, 1'b0);

    // Random traffic, back-pressure and the occasional reset.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      logic [N-1:0] rv, rl;
      rv = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) rl[i] = ($urandom_range(0, 2) == 0);
      run_cycle(rv, rl, 16'($urandom), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 999) == 0));
    end
    for (int k = 0; k < 3; k++) run_cycle('0, '0, '0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_arbiter_qos_pkt.md
# stream_arbiter_qos_pkt

Packet-locked, QoS-aware N:1 stream arbiter with round-robin fairness among equal-priority requesters, starvation aging and a registered, full-throughput output stage. It merges STREAM_COUNT valid/ready input streams onto one output stream and tags each beat with its source ID. It is the next generation of the team's stream arbiter, for use wherever multi-beat packets must not interleave and the output path must be timing-isolated.

## Interface
- T_DATA_WIDTH, 8, data width per beat
- T_QOS__WIDTH, 4, QoS width; larger value = higher priority
- STREAM_COUNT, 4, number of input streams (>= 2)
- AGE_WIDTH, 4, width of per-stream starvation counter
- AGE_LIMIT, 8, lost arbitrations before a stream becomes urgent (1..2^AGE_WIDTH-1)
- T_ID___WIDTH, localparam, max(1, $clog2(STREAM_COUNT))

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- s_data_i  in  T_DATA_WIDTH x STREAM_COUNT  input beat data
- s_qos_i  in  T_QOS__WIDTH x STREAM_COUNT  input QoS; sampled only on a packet's first beat
- s_last_i  in  STREAM_COUNT  last beat of packet
- s_valid_i  in  STREAM_COUNT  input valid
- s_ready_o  out  STREAM_COUNT  input ready; at most one bit set
- m_data_o  out  T_DATA_WIDTH  output data (registered)
- m_qos_o  out  T_QOS__WIDTH  QoS captured at the packet's first beat, held for the whole packet
- m_id_o  out  T_ID___WIDTH  source stream index
- m_last_o  out  1  output last
- m_valid_o  out  1  output valid
- m_ready_i  in  1  output ready

## Operation
- Output slot: a single register stage; slot_free = !m_valid_o || m_ready_i. An input beat transfers when s_valid_i[g] && s_ready_o[g], and s_ready_o[g] = grant[g] && slot_free.
- FSM, two states:
  - IDLE: grant = combinational select over s_valid_i. Accepted beat with last=1 -> stay IDLE; last=0 -> LOCKED, latch id and QoS.
  - LOCKED: grant = latched id only; other streams are ignored. Accepted beat with last=1 -> IDLE.
- Select in IDLE: the effective priority of a valid stream is {urgent, qos}. Take the highest; ties go round-robin, searching from rr_ptr+1 upward with wrap. On every packet start (accepted first beat), rr_ptr <= granted id.
- Aging: on each packet start, every other stream whose valid is high increments its age counter (saturating at AGE_LIMIT). urgent = (age == AGE_LIMIT). The granted stream's counter clears to 0 on its packet start. Counters of streams with valid low hold their value.
- m_qos_o for every beat of a packet equals the first-beat QoS. A QoS change mid-packet has no effect.
- Input valid dropping mid-packet: the FSM stays LOCKED and waits; it never re-arbitrates before last.
- When no input is valid, s_ready_o is all zeros. The block does not emit speculative ready.

## Timing
- Latency: accepted beat at edge n appears on m_* from edge n+1. Throughput is 1 beat/cycle with m_ready_i held high.
- Back-to-back packets: a new packet may start in the cycle after the last beat of the previous one, with no bubble. A single-beat packet never enters LOCKED.
- m_ready_i low with m_valid_o high: m_* hold stable, s_ready_o = 0, and the FSM, rr_ptr and age counters are frozen.
- The ready path from m_ready_i to s_ready_o is combinational. The data path is registered.
- Reset (synchronous, any cycle, including mid-packet): FSM = IDLE; rr_ptr = STREAM_COUNT-1, so stream 0 wins first; ages = 0; m_valid_o = 0, m_data_o/m_qos_o/m_id_o/m_last_o = 0. Any partially transferred packet is discarded. The cycle in which rst is high accepts no beat: s_ready_o = 0.

## Structure
- Package stream_arbiter_pkg: FSM state enum (ARB_IDLE, ARB_LOCKED) and a function for effective priority width (T_QOS__WIDTH+1).
- Sub-module qos_rr_select: purely combinational. Inputs are req, per-stream effective priority and rr_ptr; outputs are a one-hot grant and the binary id. Top level holds the FSM, age counters, rr_ptr and output register.

## Test plan
- STREAM_COUNT=4, streams 0..3 valid, all qos=2, single-beat packets, m_ready_i=1 -> m_id_o sequence 0,1,2,3,0 on consecutive cycles starting one cycle after the first accept.
- Stream 1 sends a 3-beat packet (qos=1); stream 2 raises valid with qos=15 on beat 2 -> m_id_o = 1,1,1, then 2. No interleave. m_qos_o = 1 on all three beats even if s_qos_i[1] changes mid-packet.
- Stream 3 qos=0; streams 0 and 1 qos=7, always valid, single-beat packets; AGE_LIMIT=8 -> stream 3 is granted at the 9th packet start; its age then reads 0.
- m_ready_i low for 5 cycles with m_valid_o=1 -> m_* stable, s_ready_o=0, no beat lost or duplicated. After release, the beat order matches a reference queue.
- rst asserted on beat 2 of a 4-beat packet from stream 2 -> next cycle m_valid_o=0, FSM IDLE. With all streams valid afterwards, stream 0 is granted first.
- Random valid/last/qos/m_ready_i for 10k cycles -> scoreboard checks per-stream beat order, no interleave within packets, at most one s_ready_o bit set, and m_* stable while stalled.
